// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared command encoding, control states and stack defaults
package stack_unit_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int DW = 16;
  typedef enum logic [1:0] {CMD_NOP, CMD_PUSH, CMD_POP} cmd_e;
  typedef enum logic [1:0] {IDLE, RESP, FAULT} state_e;
  // Exactly one of push/pop with the strobe is a command; anything else is a no-op
  function automatic cmd_e decode(input logic s, input logic pu, input logic po);
    return (!s || pu == po) ? CMD_NOP : pu ? CMD_PUSH : CMD_POP;
  endfunction
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x DW storage, synchronous write, registered read, no reset
module stack_ram
  import stack_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // Read register only loads on a read so the last popped word is held
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/stack_unit.sv
// stack_unit: LIFO register stack with pointer, flags and one-cycle response FSM
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sSTA,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    streg1,
  input  logic [DW-1:0] pushData,
  output logic [DW-1:0] popData,
  output logic [1:0]    popReg,
  output logic          popValid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);
  cmd_e cmd;
  state_e state_q, state_d;
  logic [AW:0] sp, sp_d;
  logic [DW-1:0] rdata;
  logic do_push, do_pop, rej, ovf_q, have_q;
  assign cmd = decode(sSTA, push, pop);
  assign do_push = cmd == CMD_PUSH && !full;
  assign do_pop = cmd == CMD_POP && !empty;
  assign rej = (cmd == CMD_PUSH && full) || (cmd == CMD_POP && empty);
  assign sp_d = do_push ? sp + 1'b1 : do_pop ? sp - 1'b1 : sp;
  stack_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(do_push && !rst),
    .waddr(sp[AW-1:0]),
    .wdata(pushData),
    .re(do_pop && !rst),
    .raddr(AW'(sp - 1'b1)),
    .rdata(rdata)
  );
  // Next control state: response on accepted pop, fault on any rejection
  always_comb begin
    state_d = do_pop ? RESP : rej ? FAULT : IDLE;
  end
  // Pointer, flags, response register and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      popReg <= '0;
      have_q <= 1'b0;
      ovf_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sp <= sp_d;
      full <= sp_d == (AW+1)'(DEPTH);
      empty <= sp_d == '0;
      if (do_pop) popReg <= streg1;
      if (do_pop) have_q <= 1'b1;
      if (rej) ovf_q <= cmd == CMD_PUSH;
      state_q <= state_d;
    end
  end
  assign level = sp;
  assign popData = have_q ? rdata : '0;
  assign popValid = state_q == RESP;
  assign overflow = state_q == FAULT && ovf_q;
  assign underflow = state_q == FAULT && !ovf_q;
endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit stack entries; power of two, 4..256.
REQ-002 Parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sSTA  input  1  command strobe from controller; one-cycle pulse.
REQ-006 push  input  1  push request; qualified by sSTA.
REQ-007 pop  input  1  pop request; qualified by sSTA.
REQ-008 streg1  input  2  destination/source register index of the command.
REQ-009 pushData  input  16  value of register streg1, sampled with a push command.
REQ-010 popData  output  16  value popped from the stack.
REQ-011 popReg  output  2  register index popData belongs to.
REQ-012 popValid  output  1  one-cycle pulse, popData/popReg valid.
REQ-013 full  output  1  high when the stack holds DEPTH entries.
REQ-014 empty  output  1  high when the stack holds 0 entries.
REQ-015 level  output  AW+1  current entry count, 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse, push rejected because the stack was full.
REQ-017 underflow  output  1  one-cycle pulse, pop rejected because the stack was empty.

Function
REQ-018 Command decode: a PUSH is sSTA=1, push=1, pop=0; a POP is sSTA=1, pop=1, push=0. All other combinations are no-ops with no flag.
REQ-019 Accepted PUSH (not full), sampled at edge N: mem[sp] is written with pushData at edge N; sp and level increment at edge N.
REQ-020 Rejected PUSH (full) at edge N: memory, sp and level are unchanged; overflow=1 for the cycle following edge N.
REQ-021 Accepted POP (not empty) at edge N: sp and level decrement at edge N, and mem[sp-1] is read.
REQ-022 POP response timing: after edge N, popData=mem[sp-1], popReg=streg1 and popValid=1 for exactly one cycle. Latency is 1 cycle.
REQ-023 Rejected POP (empty) at edge N: popData and popReg are held, popValid=0, underflow=1 for one cycle, and sp is unchanged.
REQ-024 popData and popReg hold their last value until the next accepted POP.
REQ-025 Back-to-back commands on consecutive cycles are legal and are each processed per REQ-019..023. A PUSH immediately followed by a POP returns the pushed value.
REQ-026 full = (level==DEPTH); empty = (level==0). Both are registered and consistent with level in the same cycle.
REQ-027 sp is AW+1 bits wide, never wraps and never exceeds DEPTH. Memory is indexed with sp[AW-1:0].
REQ-028 Control FSM states:
- IDLE: no response pending.
- RESP: popValid asserted.
- FAULT: overflow or underflow asserted.
REQ-029 FSM transitions:
- Any state to RESP on an accepted POP.
- Any state to FAULT on a rejected PUSH or POP.
- Otherwise to IDLE.
- Every state lasts exactly one cycle.

Reset
REQ-030 rst=1 at an edge sets: sp=0, level=0, empty=1, full=0, popValid=0, overflow=0, underflow=0, popData=0, popReg=0, FSM=IDLE.
REQ-031 Memory contents are not cleared by reset.
REQ-032 Reset wins over a command in the same cycle; that command is discarded. A response pending at reset is cancelled.

Structure
REQ-033 The shared processor package holds the stack command encoding, the FSM state enum (IDLE/RESP/FAULT) and the DEPTH default.
REQ-034 Storage is one sub-module, stack_ram: DEPTH x 16, one synchronous write port and one read port registered on clk, with no reset.
REQ-035 Pointer, flag and FSM logic reside in stack_unit. There are no combinational paths from inputs to outputs.

Verification
REQ-036 Reset, then PUSH 0x1234 (streg1=2), then POP (streg1=1) -> one cycle later popValid=1, popData=0x1234, popReg=1, level=0, empty=1.
REQ-037 Push 16 values 0x0000..0x000F -> full=1, level=16. A 17th PUSH -> overflow pulse, level stays 16. 16 POPs -> data 0x000F..0x0000 in LIFO order, then empty=1.
REQ-038 POP on an empty stack -> underflow=1 for one cycle, popValid=0, level=0, popData unchanged.
REQ-039 sSTA=1 with push=pop=1, and push=1 with sSTA=0 -> no state change, no flags.
REQ-040 Push 3 values, then assert rst in the same cycle as a POP -> popValid never asserts, level=0. A subsequent PUSH 0xBEEF followed by POP returns 0xBEEF.
REQ-041 Alternating PUSH/POP on consecutive cycles, 8 pairs -> each POP returns the value pushed the cycle before, and level toggles between 0 and 1.
